u409_autoconfig: RTL and testbench

Responder side of the AUTOCONFIG address space decoded by U409. It answers 68040 bus cycles qualified by `AUTOCONFIG_SPACE` ($FF00_xxxx) and presents the nibble-wide configuration ROM of two on-board devices in chain order: board 0 is the Zorro III PCI bridge and board 1 is the Zorro II ATA port. It also latches the base addresses or shut-up commands written by Kickstart, and terminates each accepted cycle with `TAn`.

---
 rtl/u409_autoconfig_if.sv | 22 ++
 rtl/u409_autoconfig.sv | 176 +++++++++++++++++
 tb/tb_u409_autoconfig.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/u409_autoconfig_if.sv
// 68040 bus signals seen by the U409 AUTOCONFIG responder.
// Valid/ready rule: TSn low for one clock starts a cycle; TAn low for one clock ends it, with D_OUT valid while D_OE is high.
interface u409_autoconfig_if;
    logic        TSn;
    logic        RnW;
    logic        AUTOCONFIG_SPACE;
    logic [6:1]  A;
    logic [31:24] D_IN;
    logic [31:28] D_OUT;
    logic        D_OE;
    logic        TAn;

    modport master (
        output TSn, RnW, AUTOCONFIG_SPACE, A, D_IN,
        input  D_OUT, D_OE, TAn
    );

    modport slave (
        input  TSn, RnW, AUTOCONFIG_SPACE, A, D_IN,
        output D_OUT, D_OE, TAn
    );
endinterface

// File: rtl/u409_autoconfig.sv
// AUTOCONFIG responder for the two U409 boards (Z3 PCI bridge, then Z2 ATA).
// Serves nibble-wide config ROM reads, latches base addresses / shut-up and acknowledges with TAn.
module u409_autoconfig #(
    parameter logic [15:0] MFG_ID = 16'h0A1C,
    parameter logic [31:0] SERIAL = 32'h0000_0001,
    parameter logic [7:0]  TYPE0  = 8'h82,
    parameter logic [7:0]  PROD0  = 8'h01,
    parameter logic [7:0]  FLAGS0 = 8'h30,
    parameter logic [7:0]  TYPE1  = 8'hC1,
    parameter logic [7:0]  PROD1  = 8'h02,
    parameter logic [7:0]  FLAGS1 = 8'h00
) (
    input  logic                  CLK40,
    input  logic                  RESETn,
    u409_autoconfig_if.slave      bus,
    output logic [31:24]          BASE0,
    output logic [23:16]          BASE1,
    output logic [1:0]            CONFIGED,
    output logic [1:0]            SHUTUP,
    output logic                  AC_DONE,
    output logic [1:0]            o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_TERM = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_phase, w_phase_nxt;
    logic        w_capture;
    logic        r_rnw;
    logic [6:1]  r_a;
    logic [7:0]  r_d;
    logic [3:0]  r_hold, w_hold_nxt;
    logic [3:0]  r_d_out;
    logic        r_d_oe;
    logic        r_tan_n;
    logic [7:0]  r_base0, w_base0_nxt;
    logic [7:0]  r_base1, w_base1_nxt;
    logic [1:0]  r_configed, w_cfg_nxt;
    logic [1:0]  r_shutup, w_shut_nxt;
    logic        r_ac_done;
    logic        w_done_nxt;
    logic        w_board1;
    logic        w_ts_hit;
    logic [7:0]  w_rom_byte;
    logic [3:0]  w_nib_raw;
    logic [3:0]  w_nib;

    assign w_board1 = r_configed[0] | r_shutup[0];
    assign w_ts_hit = !bus.TSn && bus.AUTOCONFIG_SPACE;

    // ROM lookup for the active board; every register but 0 reads back inverted
    always_comb begin
        w_rom_byte = 8'h00;
        case (r_a[5:2])
            4'd0:    w_rom_byte = w_board1 ? TYPE1  : TYPE0;
            4'd1:    w_rom_byte = w_board1 ? PROD1  : PROD0;
            4'd2:    w_rom_byte = w_board1 ? FLAGS1 : FLAGS0;
            4'd4:    w_rom_byte = MFG_ID[15:8];
            4'd5:    w_rom_byte = MFG_ID[7:0];
            4'd6:    w_rom_byte = SERIAL[31:24];
            4'd7:    w_rom_byte = SERIAL[23:16];
            4'd8:    w_rom_byte = SERIAL[15:8];
            4'd9:    w_rom_byte = SERIAL[7:0];
            default: w_rom_byte = 8'h00;
        endcase
        w_nib_raw = r_a[1] ? w_rom_byte[3:0] : w_rom_byte[7:4];
        if (r_a[6])
            w_nib = 4'hF;
        else if (r_a[5:2] != 4'd0)
            w_nib = ~w_nib_raw;
        else
            w_nib = w_nib_raw;
    end

    // Write side effects, committed on the edge that leaves TERM
    always_comb begin
        w_base0_nxt = r_base0;
        w_base1_nxt = r_base1;
        w_hold_nxt  = r_hold;
        w_cfg_nxt   = r_configed;
        w_shut_nxt  = r_shutup;
        if (r_state == S_TERM && !r_rnw) begin
            case (r_a)
                6'h22: if (!w_board1) begin
                    w_base0_nxt  = r_d;
                    w_cfg_nxt[0] = 1'b1;
                end
                6'h24: if (w_board1) w_hold_nxt = r_d[7:4];
                6'h25: if (w_board1) begin
                    w_base1_nxt  = {r_hold, r_d[7:4]};
                    w_cfg_nxt[1] = 1'b1;
                end
                6'h26: begin
                    if (w_board1) w_shut_nxt[1] = 1'b1;
                    else          w_shut_nxt[0] = 1'b1;
                end
                default: ;
            endcase
        end
        w_done_nxt = (w_cfg_nxt[0] | w_shut_nxt[0]) & (w_cfg_nxt[1] | w_shut_nxt[1]);
    end

    // ACTIVE spans two clocks so TAn lands on k+2; a new TSn may be taken on the TERM exit edge
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: if (w_ts_hit && !r_ac_done) begin
                w_state_nxt = S_ACTIVE;
                w_capture   = 1'b1;
            end
            S_ACTIVE: begin
                if (!r_phase) w_phase_nxt = 1'b1;
                else          w_state_nxt = S_TERM;
            end
            S_TERM: begin
                w_state_nxt = S_IDLE;
                if (w_ts_hit && !w_done_nxt) begin
                    w_state_nxt = S_ACTIVE;
                    w_capture   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            r_state    <= S_IDLE;
            r_phase    <= 1'b0;
            r_rnw      <= 1'b1;
            r_a        <= '0;
            r_d        <= '0;
            r_hold     <= '0;
            r_d_out    <= 4'hF;
            r_d_oe     <= 1'b0;
            r_tan_n    <= 1'b1;
            r_base0    <= '0;
            r_base1    <= '0;
            r_configed <= '0;
            r_shutup   <= '0;
            r_ac_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_tan_n    <= (w_state_nxt != S_TERM);
            r_hold     <= w_hold_nxt;
            r_base0    <= w_base0_nxt;
            r_base1    <= w_base1_nxt;
            r_configed <= w_cfg_nxt;
            r_shutup   <= w_shut_nxt;
            r_ac_done  <= w_done_nxt;
            if (w_capture) begin
                r_rnw <= bus.RnW;
                r_a   <= bus.A;
                r_d   <= bus.D_IN;
            end
            if (r_state == S_ACTIVE && !r_phase) begin
                r_d_out <= w_nib;
                r_d_oe  <= r_rnw;
            end else if (r_state == S_TERM) begin
                r_d_oe  <= 1'b0;
            end
        end
    end

    assign bus.D_OUT   = r_d_out;
    assign bus.D_OE    = r_d_oe;
    assign bus.TAn     = r_tan_n;
    assign BASE0       = r_base0;
    assign BASE1       = r_base1;
    assign CONFIGED    = r_configed;
    assign SHUTUP      = r_shutup;
    assign AC_DONE     = r_ac_done;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_u409_autoconfig.sv
// Directed bench for u409_autoconfig: driver tasks issue bus cycles, a TAn monitor checks read data from a queue.
module tb_u409_autoconfig;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  u409_autoconfig_if bus();
  logic [31:24] base0;
  logic [23:16] base1;
  logic [1:0]   configed;
  logic [1:0]   shutup;
  logic         ac_done;
  logic [1:0]   dbg_state;

  u409_autoconfig dut (
    .CLK40(clk), .RESETn(rst_n), .bus(bus),
    .BASE0(base0), .BASE1(base1), .CONFIGED(configed), .SHUTUP(shutup),
    .AC_DONE(ac_done), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];   // {is_read, expected nibble}
  logic [4:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every TAn pulse consumes one expected response
  always @(negedge clk) begin
    if (rst_n && bus.TAn === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_tan: got TAn low expected no cycle");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[4]) begin
          check("rd_oe", {31'd0, bus.D_OE}, 32'd1);
          check("rd_data", {28'd0, bus.D_OUT}, {28'd0, mon_e[3:0]});
        end else begin
          check("wr_oe", {31'd0, bus.D_OE}, 32'd0);
        end
      end
    end
  end

  task automatic drive_ts(input logic rnw, input logic [7:0] off, input logic [7:0] data);
    bus.TSn = 1'b0;
    bus.RnW = rnw;
    bus.AUTOCONFIG_SPACE = 1'b1;
    bus.A = off[6:1];
    bus.D_IN = data;
  endtask

  task automatic release_ts();
    bus.TSn = 1'b1;
    bus.AUTOCONFIG_SPACE = 1'b0;
  endtask

  task automatic bus_cycle(input logic rnw, input logic [7:0] off, input logic [7:0] data,
                           input logic [3:0] nib, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    drive_ts(rnw, off, data);
    exp_q.push_back({rnw, nib});
    @(negedge clk);
    release_ts();
    seen = 0;
    lat = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.TAn === 1'b0) begin
        seen = 1;
        lat = i;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no TAn in 10 clocks expected one", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check({name, "_latency"}, lat, 1);
      @(negedge clk);
      check({name, "_tan_width"}, {31'd0, bus.TAn}, 32'd1);
    end
  endtask

  task automatic rd(input logic [7:0] off, input logic [3:0] nib);
    bus_cycle(1'b1, off, 8'h00, nib, $sformatf("rd_%02h", off));
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] data);
    bus_cycle(1'b0, off, data, 4'h0, $sformatf("wr_%02h", off));
  endtask

  task automatic count_tan(input int clocks, output int pulses);
    pulses = 0;
    for (int i = 0; i < clocks; i++) begin
      @(negedge clk);
      if (bus.TAn === 1'b0) pulses++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_status(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [1:0] cf, input logic [1:0] su, input logic dn);
    check({name, "_base0"}, {24'd0, base0}, {24'd0, b0});
    check({name, "_base1"}, {24'd0, base1}, {24'd0, b1});
    check({name, "_configed"}, {30'd0, configed}, {30'd0, cf});
    check({name, "_shutup"}, {30'd0, shutup}, {30'd0, su});
    check({name, "_ac_done"}, {31'd0, ac_done}, {31'd0, dn});
  endtask

  initial begin
    int pulses;
    bus.TSn = 1'b1;
    bus.RnW = 1'b1;
    bus.AUTOCONFIG_SPACE = 1'b0;
    bus.A = '0;
    bus.D_IN = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_tan", {31'd0, bus.TAn}, 32'd1);
    check("reset_oe", {31'd0, bus.D_OE}, 32'd0);
    check("reset_dout", {28'd0, bus.D_OUT}, 32'hF);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    check_status("reset", 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);

    // Board 0 ROM: TYPE true, the rest inverted, write space reads $F
    rd(8'h00, 4'h8);
    rd(8'h02, 4'h2);
    rd(8'h04, 4'hF);
    rd(8'h06, 4'hE);
    rd(8'h08, 4'hC);
    rd(8'h10, 4'hF);
    rd(8'h12, 4'h5);
    rd(8'h18, 4'hF);
    rd(8'h26, 4'hE);
    rd(8'h2C, 4'hF);
    rd(8'h40, 4'hF);

    // Reset lands on k+1 of a $44 write: cycle dropped
    @(negedge clk);
    drive_ts(1'b0, 8'h44, 8'h40);
    @(negedge clk);
    release_ts();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_tan(6, pulses);
    check("rst_inflight_tan", pulses, 0);
    check_status("rst_inflight", 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);
    rd(8'h00, 4'h8);

    // Configure board 0, board 1 ROM appears
    wr(8'h44, 8'h40);
    check_status("cfg0", 8'h40, 8'h00, 2'b01, 2'b00, 1'b0);
    rd(8'h00, 4'hC);
    rd(8'h02, 4'h1);
    rd(8'h06, 4'hD);

    // TSn held for a second edge during an active read
    @(negedge clk);
    drive_ts(1'b1, 8'h00, 8'h00);
    exp_q.push_back({1'b1, 4'hC});
    @(negedge clk);
    @(negedge clk);
    release_ts();
    count_tan(8, pulses);
    check("double_ts_pulses", pulses, 1);

    wr(8'h50, 8'h12);
    wr(8'h44, 8'h77);
    check_status("ignored_wr", 8'h40, 8'h00, 2'b01, 2'b00, 1'b0);

    wr(8'h48, 8'h70);
    wr(8'h48, 8'hE0);
    check_status("hold_only", 8'h40, 8'h00, 2'b01, 2'b00, 1'b0);
    wr(8'h4A, 8'h90);
    check_status("cfg1", 8'h40, 8'hE9, 2'b11, 2'b00, 1'b1);

    @(negedge clk);
    drive_ts(1'b1, 8'h00, 8'h00);
    @(negedge clk);
    release_ts();
    count_tan(20, pulses);
    check("done_no_tan", pulses, 0);

    // Shut-up path from a fresh reset
    do_reset();
    check_status("reset2", 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);
    wr(8'h4C, 8'h00);
    check_status("shut0", 8'h00, 8'h00, 2'b00, 2'b01, 1'b0);
    rd(8'h00, 4'hC);
    wr(8'h4C, 8'h00);
    check_status("shut1", 8'h00, 8'h00, 2'b00, 2'b11, 1'b1);
    @(negedge clk);
    drive_ts(1'b1, 8'h02, 8'h00);
    @(negedge clk);
    release_ts();
    count_tan(10, pulses);
    check("shut_no_tan", pulses, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within 200us");
    $fatal(1);
  end
endmodule
